// File: rtl/lsu_if.sv
// Data-memory side bundle of the load/store unit: execute-stage request,
// one-cycle response and the byte-addressed memory port.
interface lsu_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  logic [XLEN-1:0] mem_addr;
  logic [1:0]      mem_sel;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_sel, mem_wen, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_sel, mem_wen, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one request at a time, misaligned half/word
// accesses are broken into little-endian byte beats.
module lsu #(
  parameter int XLEN = 32
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, DONE} state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic [1:0]      k_q, k_d;
  logic [XLEN-1:0] wdata_sh;
  logic            illegal;

  function automatic logic illegal_op(input logic we, input logic [2:0] f3);
    return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a_lo);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return !a_lo[0];
      default: return a_lo == 2'b00;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] mask_size(input logic [1:0] sz,
                                                input logic [XLEN-1:0] d);
    case (sz)
      2'd0:    return {{(XLEN-8){1'b0}}, d[7:0]};
      2'd1:    return {{(XLEN-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                               input logic [XLEN-1:0] d);
    logic signed [XLEN-1:0] r;
    case (f3)
      3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
      3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
      3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign illegal = illegal_op(bus.req_we, bus.req_funct3);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    err_d    = err_q;
    k_d      = k_q;
    wdata_sh = wdata_q >> {k_q, 3'b000};

    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_sel   = 2'd0;
    bus.mem_wen   = 1'b0;
    bus.mem_wdata = '0;

    case (state_q)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid && !rst) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          data_d  = '0;
          k_d     = 2'd0;
          err_d   = illegal;
          if (illegal)
            state_d = DONE;
          else if (is_aligned(bus.req_funct3[1:0], bus.req_addr[1:0]))
            state_d = ACCESS;
          else
            state_d = SPLIT;
        end
      end
      ACCESS: begin
        bus.mem_addr  = addr_q;
        bus.mem_sel   = f3_q[1:0];
        bus.mem_wen   = we_q;
        bus.mem_wdata = mask_size(f3_q[1:0], wdata_q);
        if (!we_q)
          data_d = mask_size(f3_q[1:0], bus.mem_rdata);
        state_d = DONE;
      end
      SPLIT: begin
        // Beat k moves byte k; the address wraps naturally at 2^XLEN.
        bus.mem_addr  = addr_q + XLEN'(k_q);
        bus.mem_sel   = 2'd0;
        bus.mem_wen   = we_q;
        bus.mem_wdata = {{(XLEN-8){1'b0}}, wdata_sh[7:0]};
        if (!we_q)
          data_d[{k_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
        if (k_q == ((f3_q[1:0] == 2'd1) ? 2'd1 : 2'd3))
          state_d = DONE;
        else
          k_d = k_q + 2'd1;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = (we_q || err_q) ? '0 : load_ext(f3_q, data_q);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the data-memory port. Accepts one RV32I load or store request at a time from the execute stage, drives the memory's `addr`/`sel`/`wen`/`data_i`/`data_o` port, splits misaligned halfword/word accesses into byte beats, and returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface

- `XLEN`, 32, data and address width; only 32 is supported.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept; a request is taken when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `rsp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  illegal funct3; qualified by `rsp_valid`.
- `mem_addr`  out  XLEN  memory byte address.
- `mem_sel`  out  2  access size: 0 byte, 1 half, 2 word; 3 never driven.
- `mem_wen`  out  1  memory write enable.
- `mem_wdata`  out  XLEN  write data, right-aligned; unused upper bits 0.
- `mem_rdata`  in  XLEN  memory read data, right-aligned; combinational from `mem_addr`/`mem_sel`; upper bits beyond `mem_sel` width are ignored.

## Operation

- States: IDLE, ACCESS, SPLIT, DONE.
- IDLE:
  - `req_ready = !rst`.
  - On handshake, latch `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
  - Illegal op goes to DONE with err. Illegal ops are funct3 011/110/111, or a store with funct3 100/101.
  - Aligned op goes to ACCESS. Aligned means: byte always; half when addr[0]=0; word when addr[1:0]=0.
  - Otherwise goes to SPLIT with beat counter k=0.
- ACCESS, one cycle:
  - `mem_addr = addr`, `mem_sel` = op size, `mem_wen = we`, `mem_wdata` = wdata masked to size.
  - Load: capture `mem_rdata` masked to size at the rising edge.
  - Then DONE.
- SPLIT, N beats (N = 2 half, 4 word), k = 0..N-1:
  - `mem_addr = addr + k`, `mem_sel = 0`, `mem_wen = we`, `mem_wdata = {24'b0, wdata[8k+7:8k]}`.
  - Load: captures `mem_rdata[7:0]` into byte k of the assembly register (little-endian).
  - After beat N-1, go to DONE.
  - Address arithmetic wraps modulo 2^32: addr 0xFFFFFFFF + 1 = 0x0.
- DONE, one cycle:
  - `rsp_valid = 1`, `req_ready = 0`.
  - `rsp_rdata`: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unchanged; stores and errors give 0.
  - `rsp_err = 1` only for illegal op.
  - Then IDLE.
- Outside ACCESS/SPLIT, `mem_addr`, `mem_sel`, `mem_wdata` are 0 and `mem_wen` is 0.
- Reset:
  - Next edge forces IDLE and clears latched request, counter and assembly register.
  - An in-flight split store may leave memory partially written; no response is issued for the aborted op.

## Timing

- Request accepted at edge T.
- Aligned: ACCESS in cycle T..T+1; `rsp_valid` in cycle T+1..T+2; `req_ready` high again from edge T+2.
- Misaligned, N beats: beats occupy N cycles; `rsp_valid` N+1 cycles after acceptance.
- Illegal: `rsp_valid` in the cycle immediately after acceptance; no memory cycle.
- `mem_wen` high exactly one cycle per beat; one write per beat at the memory's rising edge.
- Back-to-back: with `req_valid` held high, requests are accepted every 3 cycles for aligned ops.
- Reset values (cycle after a reset edge): `req_ready` 1 once `rst` low, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `mem_addr` 0, `mem_sel` 0, `mem_wen` 0, `mem_wdata` 0.
- `req_*` inputs are ignored when `req_ready` is 0.

## Test plan

- SW addr 0x8 data 0xDEADBEEF, then LW 0x8:
  - store: one cycle with `mem_sel`=2, `mem_wen`=1, `mem_addr`=0x8;
  - load: `rsp_rdata`=0xDEADBEEF, `rsp_valid` 2 cycles after acceptance.
- After the above:
  - LB 0xB → 0xFFFFFFDE;
  - LBU 0xB → 0x000000DE;
  - LH 0xA → 0xFFFFDEAD;
  - LHU 0x8 → 0x0000BEEF;
  - SB 0x9 data 0x12345677, then LW 0x8 → 0xDEAD77EF.
- SW addr 0x11 data 0x11223344:
  - 4 beats, `mem_addr` 0x11..0x14, `mem_sel`=0, `mem_wdata` 0x44, 0x33, 0x22, 0x11;
  - then LW 0x11 → 0x11223344 with `rsp_valid` 5 cycles after acceptance;
  - LH 0x13 → 0x00001122.
- Load funct3=011 at addr 0x0: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 one cycle after acceptance; `mem_wen` never asserted.
- Misaligned SW addr 0x21 with `rst` pulsed during beat 2:
  - next cycle `mem_wen`=0 and all outputs at reset values;
  - no `rsp_valid`;
  - `req_ready`=1 after `rst` drops;
  - a subsequent LW 0x8 completes normally.
- Three aligned loads presented with `req_valid` held high: accepted at edges T, T+3, T+6; `rsp_valid` at T+2, T+5, T+8.
